// File: rtl/game_state_ctrl_if.sv
// Collision/start inputs and game-state outputs between the game logic and the controller.
// The bonus signal exists only when LIFE_BONUS_EN is defined.
interface game_state_ctrl_if;
  logic       start;
  logic       hit;
`ifdef LIFE_BONUS_EN
  logic       bonus;
`endif
  logic       gameover;
  logic       playing;
  logic       invuln;
  logic [2:0] lives;
  logic       lose_life;

`ifdef LIFE_BONUS_EN
  modport master (output start, hit, bonus,
                  input  gameover, playing, invuln, lives, lose_life);
  modport slave  (input  start, hit, bonus,
                  output gameover, playing, invuln, lives, lose_life);
`else
  modport master (output start, hit,
                  input  gameover, playing, invuln, lives, lose_life);
  modport slave  (input  start, hit,
                  output gameover, playing, invuln, lives, lose_life);
`endif
endinterface

// File: rtl/game_state_ctrl.sv
// Lives / invulnerability / game-over controller feeding the LED and display blocks.
// Optional LIFE_BONUS_EN adds a saturating extra-life input.
module game_state_ctrl #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned MAX_LIVES     = 7,
  parameter logic [27:0] INVULN_CYCLES = 28'd50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  game_state_ctrl_if.slave  bus
);

  localparam int unsigned LIVES_W = 3;
  localparam int unsigned CNT_W   = 28;
  localparam logic [LIVES_W-1:0] LIVES_INIT =
    LIVES_W'((START_LIVES > MAX_LIVES) ? MAX_LIVES : START_LIVES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_INVULN = 2'd2,
    S_OVER   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                start_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                lose_life_q, lose_life_d;
  logic                gameover_q, gameover_d;
  logic                playing_q, playing_d;
  logic                invuln_q, invuln_d;
  logic                start_edge_c;
  logic                bonus_c;

  // start_q resets high so a key held through reset must be released first
  assign start_edge_c = bus.start & ~start_q;

`ifdef LIFE_BONUS_EN
  localparam logic [LIVES_W-1:0] LIVES_CAP = LIVES_W'(MAX_LIVES);
  logic [LIVES_W-1:0] lives_inc_c;
  assign bonus_c     = bus.bonus;
  assign lives_inc_c = (lives_q >= LIVES_CAP) ? lives_q : lives_q + LIVES_W'(1);
`else
  assign bonus_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a hit paired with a bonus can never be fatal
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_edge_c) state_d = S_PLAY;
      S_PLAY: begin
        if (bus.hit) begin
          if (bonus_c || lives_q > LIVES_W'(1)) state_d = S_INVULN;
          else                                  state_d = S_OVER;
        end
      end
      S_INVULN: if (cnt_q == '0) state_d = S_PLAY;
      S_OVER:   if (start_edge_c) state_d = S_PLAY;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lives_d     = lives_q;
    cnt_d       = cnt_q;
    lose_life_d = 1'b0;
    case (state_q)
      S_IDLE: if (start_edge_c) lives_d = LIVES_INIT;
      S_PLAY: begin
        if (bus.hit && lives_q != '0) begin
          lose_life_d = 1'b1;
          cnt_d       = INVULN_CYCLES - CNT_W'(1);
          if (!bonus_c) lives_d = lives_q - LIVES_W'(1);
        end
`ifdef LIFE_BONUS_EN
        else if (bonus_c) lives_d = lives_inc_c;
`endif
      end
      S_INVULN: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
`ifdef LIFE_BONUS_EN
        if (bonus_c) lives_d = lives_inc_c;
`endif
      end
      S_OVER: lives_d = start_edge_c ? LIVES_INIT : '0;
      default: lives_d = LIVES_INIT;
    endcase
    gameover_d = (state_d == S_OVER);
    playing_d  = (state_d == S_PLAY) || (state_d == S_INVULN);
    invuln_d   = (state_d == S_INVULN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q     <= 1'b1;
      cnt_q       <= '0;
      lives_q     <= LIVES_INIT;
      lose_life_q <= 1'b0;
      gameover_q  <= 1'b0;
      playing_q   <= 1'b0;
      invuln_q    <= 1'b0;
    end else begin
      start_q     <= bus.start;
      cnt_q       <= cnt_d;
      lives_q     <= lives_d;
      lose_life_q <= lose_life_d;
      gameover_q  <= gameover_d;
      playing_q   <= playing_d;
      invuln_q    <= invuln_d;
    end
  end

  assign bus.gameover  = gameover_q;
  assign bus.playing   = playing_q;
  assign bus.invuln    = invuln_q;
  assign bus.lives     = lives_q;
  assign bus.lose_life = lose_life_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed vector bench for game_state_ctrl with INVULN_CYCLES=4, START_LIVES=3, MAX_LIVES=7.
module tb_game_state_ctrl;

  typedef struct {
    logic       rst;
    logic       start;
    logic       hit;
    logic       bonus;
    logic       gameover;
    logic       playing;
    logic       invuln;
    logic [2:0] lives;
    logic       lose_life;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .START_LIVES   (3),
    .MAX_LIVES     (7),
    .INVULN_CYCLES (28'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void add(input logic r, input logic s, input logic h, input logic b,
                              input logic g, input logic p, input logic i,
                              input logic [2:0] l, input logic ll);
    vec_t v;
    v.rst = r; v.start = s; v.hit = h; v.bonus = b;
    v.gameover = g; v.playing = p; v.invuln = i; v.lives = l; v.lose_life = ll;
    vecs.push_back(v);
  endfunction

  task automatic set_bonus(input logic b);
`ifdef LIFE_BONUS_EN
    bus.bonus = b;
`else
    if (b) $display("note: bonus request ignored in this build");
`endif
  endtask

  task automatic check_state(input string tag, input int g, input int p, input int i,
                             input int l, input int ll);
    check({tag, ".gameover"}, int'(bus.gameover), g);
    check({tag, ".playing"},  int'(bus.playing),  p);
    check({tag, ".invuln"},   int'(bus.invuln),   i);
    check({tag, ".lives"},    int'(bus.lives),    l);
    check({tag, ".lose_life"}, int'(bus.lose_life), ll);
  endtask

  initial begin
    int n_inv;
    int n_pulse;
    int exp_l;
    bit ok;

    // reset with start held high: no game may begin
    for (int k = 0; k < 10; k++) add(1, 1, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 1, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 1, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 0, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 1, 0, 0, 0, 1, 0, 3'd3, 0);
    add(0, 1, 0, 0, 0, 1, 0, 3'd3, 0);
    // first hit then four invulnerable cycles ignoring hits
    add(0, 0, 1, 0, 0, 1, 1, 3'd2, 1);
    add(0, 0, 1, 0, 0, 1, 1, 3'd2, 0);
    add(0, 0, 1, 0, 0, 1, 1, 3'd2, 0);
    add(0, 0, 1, 0, 0, 1, 1, 3'd2, 0);
    add(0, 0, 1, 0, 0, 1, 0, 3'd2, 0);
    add(0, 0, 0, 0, 0, 1, 0, 3'd2, 0);
    add(0, 0, 1, 0, 0, 1, 1, 3'd1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 3'd1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 3'd1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 3'd1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 3'd1, 0);
    // fatal hit, hits in OVER ignored, restart with simultaneous hit
    add(0, 0, 1, 0, 1, 0, 0, 3'd0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 3'd0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 3'd0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 3'd3, 0);
    add(0, 0, 0, 0, 0, 1, 0, 3'd3, 0);
    // start edge with hit in PLAY: hit wins
    add(0, 1, 1, 0, 0, 1, 1, 3'd2, 1);
    add(0, 0, 0, 0, 0, 1, 1, 3'd2, 0);
    // reset during invuln cycle 2
    add(1, 0, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 0, 0, 0, 0, 0, 0, 3'd3, 0);
    add(0, 0, 1, 0, 0, 0, 0, 3'd3, 0);
    add(0, 1, 0, 0, 0, 1, 0, 3'd3, 0);

    reset = 1'b1; bus.start = 1'b1; bus.hit = 1'b0;
    set_bonus(1'b0);

    foreach (vecs[k]) begin
      reset     = vecs[k].rst;
      bus.start = vecs[k].start;
      bus.hit   = vecs[k].hit;
      set_bonus(vecs[k].bonus);
      tick();
      check_state($sformatf("vec%0d", k), int'(vecs[k].gameover), int'(vecs[k].playing),
                  int'(vecs[k].invuln), int'(vecs[k].lives), int'(vecs[k].lose_life));
    end
    bus.hit = 1'b0;

    // invuln window length and pulse count, measured with a bounded loop
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b1;
    n_inv = 0; n_pulse = 0; ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!bus.invuln) break;
      n_inv++;
      n_pulse += int'(bus.lose_life);
      if (!bus.playing) ok = 1'b0;
      tick();
    end
    bus.hit = 1'b0;
    check("invuln_len", n_inv, 4);
    check("lose_pulses", n_pulse, 1);
    check("playing_during_invuln", int'(ok), 1);
    check("lives_after_window", int'(bus.lives), 2);

`ifdef LIFE_BONUS_EN
    // bonus pulses saturate at MAX_LIVES
    exp_l = 2;
    for (int k = 0; k < 6; k++) begin
      bus.bonus = 1'b1; tick();
      bus.bonus = 1'b0;
      exp_l = (exp_l < 7) ? exp_l + 1 : 7;
      check($sformatf("bonus%0d.lives", k), int'(bus.lives), exp_l);
    end
    // bring lives down to 1 from a fresh game
    reset = 1'b1; tick();
    reset = 1'b0; bus.start = 1'b0; tick();
    bus.start = 1'b1; tick();
    check_state("bonus_restart", 0, 1, 0, 3, 0);
    for (int h = 0; h < 2; h++) begin
      bus.hit = 1'b1; tick();
      bus.hit = 1'b0;
      for (int k = 0; k < 10 && bus.invuln; k++) tick();
      check($sformatf("bonus_back_to_play%0d", h), int'(bus.invuln), 0);
    end
    check("bonus_pre.lives", int'(bus.lives), 1);
    bus.hit = 1'b1; bus.bonus = 1'b1; tick();
    bus.hit = 1'b0; bus.bonus = 1'b0;
    check_state("hit_bonus", 0, 1, 1, 1, 1);
    bus.bonus = 1'b1; tick();
    bus.bonus = 1'b0;
    check("bonus_in_invuln.lives", int'(bus.lives), 2);
`else
    // without the bonus option lives only fall: one more hit takes 2 -> 1
    exp_l = 1;
    bus.hit = 1'b1; tick();
    bus.hit = 1'b0;
    check("final_hit.lives", int'(bus.lives), exp_l);
    check("final_hit.lose_life", int'(bus.lose_life), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
